// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction prefetch queue for the STRV32I front end.
// Issues sequential word fetches over a req/ack memory handshake, buffers
// returned words with their PCs in a circular queue, and presents the head
// to decode on a valid/ready interface. Redirects flush the queue; a fetch
// still in flight at redirect time is allowed to complete and is discarded.
module fetch_queue_unit #(
    parameter int                XLEN     = 32,
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     redirect_in,
    input  logic [XLEN-1:0]          redirect_pc_in,
    output logic                     imreq_out,
    output logic [XLEN-1:0]          imaddr_out,
    input  logic                     imack_in,
    input  logic [31:0]              imdata_in,
    output logic                     inst_valid_out,
    output logic [31:0]              inst_out,
    output logic [XLEN-1:0]          inst_pc_out,
    input  logic                     inst_ready_in,
    output logic                     misaligned_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_STALE = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    // Fetch targets must be word aligned; anything else parks the unit in FAULT.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pending_pc;
    logic [XLEN-1:0] pending_next;
    logic [XLEN-1:0] stale_target;
    logic            flush;

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;
    logic            has_room;

    logic [31:0]     mem_inst [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];

    // A redirect cycle hides the head so decode never consumes a flushed entry.
    assign inst_valid_out = (count != '0) && !redirect_in;
    assign pop            = inst_valid_out && inst_ready_in;
    assign push           = (state == ST_REQ) && imack_in && !redirect_in;
    assign count_next     = count + CW'(push) - CW'(pop);
    assign has_room       = count_next < CW'(DEPTH);

    // When the stale fetch finally completes, a redirect in that same cycle wins.
    assign stale_target   = redirect_in ? redirect_pc_in : pending_pc;

    assign imreq_out      = (state == ST_REQ) || (state == ST_STALE);
    assign imaddr_out     = pc_q;
    assign misaligned_out = (state == ST_FAULT);
    assign count_out      = count;

    // Head data is zeroed when nothing is presented, which also gives clean reset values.
    assign inst_out       = inst_valid_out ? mem_inst[head] : '0;
    assign inst_pc_out    = inst_valid_out ? mem_pc[head]   : '0;

    // Fetch FSM: next state, next fetch address, pending redirect target and flush.
    always_comb begin
        state_next   = state;
        pc_next      = pc_q;
        pending_next = pending_pc;
        flush        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (redirect_in) begin
                    flush      = 1'b1;
                    pc_next    = redirect_pc_in;
                    state_next = is_misaligned(redirect_pc_in) ? ST_FAULT : ST_REQ;
                end else if (has_room) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_in) begin
                    flush = 1'b1;
                    if (imack_in) begin
                        pc_next    = redirect_pc_in;
                        state_next = is_misaligned(redirect_pc_in) ? ST_FAULT : ST_REQ;
                    end else begin
                        // Bus address must stay put until the ack, so park the target.
                        pending_next = redirect_pc_in;
                        state_next   = ST_STALE;
                    end
                end else if (imack_in) begin
                    pc_next    = pc_q + XLEN'(4);
                    state_next = has_room ? ST_REQ : ST_IDLE;
                end
            end
            ST_STALE: begin
                if (redirect_in) begin
                    flush = 1'b1;
                end
                if (imack_in) begin
                    pc_next    = stale_target;
                    state_next = is_misaligned(stale_target) ? ST_FAULT : ST_REQ;
                end else if (redirect_in) begin
                    pending_next = redirect_pc_in;
                end
            end
            ST_FAULT: begin
                if (redirect_in) begin
                    flush      = 1'b1;
                    pc_next    = redirect_pc_in;
                    state_next = is_misaligned(redirect_pc_in) ? ST_FAULT : ST_REQ;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control registers: FSM state, fetch PC, queue pointers and occupancy.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
            pc_q  <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            pc_q  <= pc_next;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                count <= count_next;
                if (pop) begin
                    head <= head + PW'(1);
                end
                if (push) begin
                    tail <= tail + PW'(1);
                end
            end
        end
    end

    // Pending redirect target is only read after being written in STALE entry.
    always_ff @(posedge clk_in) begin
        pending_pc <= pending_next;
    end

    // Queue storage: write the returned word and its PC at the tail.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_inst[tail] <= imdata_in;
            mem_pc[tail]   <= pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a queue of expected {inst, pc} words.
module tb_fetch_queue_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imreq;
    logic [31:0] imaddr;
    logic        imack;
    logic [31:0] imdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        ready;
    logic        misaligned;
    logic [2:0]  count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_addr;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .redirect_in(redirect),
        .redirect_pc_in(redirect_pc),
        .imreq_out(imreq),
        .imaddr_out(imaddr),
        .imack_in(imack),
        .imdata_in(imdata),
        .inst_valid_out(inst_valid),
        .inst_out(inst),
        .inst_pc_out(inst_pc),
        .inst_ready_in(ready),
        .misaligned_out(misaligned),
        .count_out(count)
    );

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return ~a ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Settle, compare the head against the scoreboard if decode takes it, then clock.
    task automatic tick();
        logic [63:0] e;
        #1;
        if (inst_valid && ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL pop_unexpected observed_pc=%h expected=none", inst_pc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_inst", 64'(inst), 64'(e[63:32]));
                chk("pop_pc", 64'(inst_pc), 64'(e[31:0]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_imreq", 64'(imreq), 64'd0);
        chk("rst_imaddr", 64'(imaddr), 64'(RESET_PC));
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_pc", 64'(inst_pc), 64'd0);
        chk("rst_misaligned", 64'(misaligned), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
    endtask

    // Assert reset between edges, check values without a clock edge, then release.
    task automatic do_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        imack    = 1'b0;
        #2;
        check_reset_vals();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_addr = RESET_PC;
        chk("first_req", 64'(imreq), 64'd1);
        chk("first_addr", 64'(imaddr), 64'(RESET_PC));
    endtask

    // Zero-wait ack of the expected address; its word must later reach decode.
    task automatic ack_push();
        chk("req_hi", 64'(imreq), 64'd1);
        chk("req_addr", 64'(imaddr), 64'(exp_addr));
        imack  = 1'b1;
        imdata = fdata(exp_addr);
        exp_q.push_back({fdata(exp_addr), exp_addr});
        exp_addr = exp_addr + 32'd4;
        tick();
        imack = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imack       = 1'b0;
        imdata      = '0;
        ready       = 1'b1;
        exp_addr    = RESET_PC;

        // Streaming with zero-wait memory and decode always ready.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ack_push();
            chk("stream_cnt_le1", 64'(count <= 3'd1), 64'd1);
        end
        tick();
        chk("stream_drained", 64'(count), 64'd0);

        // Fill the queue with decode stalled, then free one slot.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ack_push();
        end
        chk("full_noreq", 64'(imreq), 64'd0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_valid", 64'(inst_valid), 64'd1);
        tick();
        chk("full_hold_noreq", 64'(imreq), 64'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("slot_count", 64'(count), 64'd3);
        ack_push();
        chk("refull_count", 64'(count), 64'd4);
        chk("refull_noreq", 64'(imreq), 64'd0);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        chk("drain_count", 64'(count), 64'd0);

        // Redirect while a slow fetch at 0x8 is outstanding.
        do_reset();
        ack_push();
        ack_push();
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        #1;
        chk("redir_mask_valid", 64'(inst_valid), 64'd0);
        tick();
        exp_q.delete();
        redirect_pc = 32'h100;
        chk("stale_addr_w2", 64'(imaddr), 64'h8);
        chk("stale_req_w2", 64'(imreq), 64'd1);
        tick();
        redirect = 1'b0;
        chk("stale_addr_w3", 64'(imaddr), 64'h8);
        chk("stale_count", 64'(count), 64'd0);
        chk("stale_valid", 64'(inst_valid), 64'd0);
        tick();
        chk("stale_addr_ack", 64'(imaddr), 64'h8);
        imack  = 1'b1;
        imdata = fdata(32'h8);
        tick();
        imack = 1'b0;
        chk("post_stale_valid", 64'(inst_valid), 64'd0);
        chk("post_stale_count", 64'(count), 64'd0);
        exp_addr = 32'h100;
        ack_push();

        // Misaligned redirect with a coincident ack, then recovery.
        imack       = 1'b1;
        imdata      = 32'hDEAD_BEEF;
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        #1;
        chk("mis_mask_valid", 64'(inst_valid), 64'd0);
        tick();
        exp_q.delete();
        imack    = 1'b0;
        redirect = 1'b0;
        chk("fault_mis", 64'(misaligned), 64'd1);
        chk("fault_noreq", 64'(imreq), 64'd0);
        chk("fault_valid", 64'(inst_valid), 64'd0);
        chk("fault_count", 64'(count), 64'd0);
        chk("fault_addr", 64'(imaddr), 64'h102);
        tick();
        chk("fault_hold", 64'(misaligned), 64'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk("recover_mis", 64'(misaligned), 64'd0);
        exp_addr = 32'h200;
        ack_push();
        #1;
        chk("recover_valid", 64'(inst_valid), 64'd1);
        tick();

        // Fetch address wraps past the top of the address space.
        ready       = 1'b0;
        imack       = 1'b1;
        imdata      = 32'hCAFE_F00D;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        exp_q.delete();
        imack    = 1'b0;
        redirect = 1'b0;
        exp_addr = 32'hFFFF_FFFC;
        ack_push();
        chk("wrap_addr", 64'(imaddr), 64'h0);
        ack_push();
        chk("two_count", 64'(count), 64'd2);
        chk("two_req", 64'(imreq), 64'd1);

        // Asynchronous reset in the middle of an outstanding request.
        #2;
        do_reset();
        ready = 1'b1;
        ack_push();
        tick();
        chk("final_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
